// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage and the ALU: ALUOp, R-type funct, ALU control codes,
// the registered control bundle and the ALU control decoder.
package id_ex_stage_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpAddi  = 2'b11;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctMul = 6'b011000;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluMul = 3'b100;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '0;

  function automatic logic [2:0] alu_ctrl_decode(input logic [1:0] alu_op,
                                                 input logic [5:0] funct);
    logic [2:0] code;
    code = AluAdd;
    if (alu_op == AluOpSub) begin
      code = AluSub;
    end else if (alu_op == AluOpRtype) begin
      case (funct)
        FunctAdd: code = AluAdd;
        FunctSub: code = AluSub;
        FunctAnd: code = AluAnd;
        FunctOr:  code = AluOr;
        FunctMul: code = AluMul;
        default:  code = AluAdd;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats register data; $0 is never forwarded.
module fwd_sel (
  input  logic [4:0]  addr_i,
  input  logic [31:0] reg_data_i,
  input  logic        exmem_we_i,
  input  logic [4:0]  exmem_addr_i,
  input  logic [31:0] exmem_data_i,
  input  logic        memwb_we_i,
  input  logic [4:0]  memwb_addr_i,
  input  logic [31:0] memwb_data_i,
  output logic [31:0] data_o
);

  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_we_i && (exmem_addr_i != 5'd0) && (exmem_addr_i == addr_i);
  assign hit_memwb = memwb_we_i && (memwb_addr_i != 5'd0) && (memwb_addr_i == addr_i);

  always_comb begin
    data_o = reg_data_i;
    if (hit_exmem) begin
      data_o = exmem_data_i;
    end else if (hit_memwb) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: ALU control decode, operand forwarding and
// load-use hazard detection with single-bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [5:0]  funct_i,
  input  logic [1:0]  ALUOp_i,
  input  logic        ALUSrc_i,
  input  logic        RegDst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RDaddr_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] MEMWB_data_i,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [2:0]  ALUCtrl_o,
  output logic [31:0] MemWdata_o,
  output logic [4:0]  WBaddr_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        hazard_o
);

  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]  rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] rs_fwd, rt_fwd;

  // Load in EX whose destination is read by the instruction now in ID.
  assign hazard_o = ctrl_q.mem_read && (rt_addr_q != 5'd0) &&
                    ((rt_addr_q == RSaddr_i) || (rt_addr_q == RTaddr_i));

  always_comb begin
    rs_data_d = RSdata_i;
    rt_data_d = RTdata_i;
    imm_d     = imm_i;
    rs_addr_d = RSaddr_i;
    rt_addr_d = RTaddr_i;
    rd_addr_d = RDaddr_i;
    ctrl_d    = '{alu_src:    ALUSrc_i,
                  reg_dst:    RegDst_i,
                  reg_write:  RegWrite_i,
                  mem_to_reg: MemtoReg_i,
                  mem_read:   MemRead_i,
                  mem_write:  MemWrite_i,
                  alu_ctrl:   alu_ctrl_decode(ALUOp_i, funct_i)};
    if (stall_i) begin
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      rd_addr_d = rd_addr_q;
      ctrl_d    = ctrl_q;
    end else if (flush_i || hazard_o) begin
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      ctrl_d    = CtrlBubble;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      ctrl_q    <= CtrlBubble;
    end else begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      ctrl_q    <= ctrl_d;
    end
  end

  fwd_sel u_fwd_rs (
    .addr_i       (rs_addr_q),
    .reg_data_i   (rs_data_q),
    .exmem_we_i   (EXMEM_RegWrite_i),
    .exmem_addr_i (EXMEM_RDaddr_i),
    .exmem_data_i (EXMEM_data_i),
    .memwb_we_i   (MEMWB_RegWrite_i),
    .memwb_addr_i (MEMWB_RDaddr_i),
    .memwb_data_i (MEMWB_data_i),
    .data_o       (rs_fwd)
  );

  fwd_sel u_fwd_rt (
    .addr_i       (rt_addr_q),
    .reg_data_i   (rt_data_q),
    .exmem_we_i   (EXMEM_RegWrite_i),
    .exmem_addr_i (EXMEM_RDaddr_i),
    .exmem_data_i (EXMEM_data_i),
    .memwb_we_i   (MEMWB_RegWrite_i),
    .memwb_addr_i (MEMWB_RDaddr_i),
    .memwb_data_i (MEMWB_data_i),
    .data_o       (rt_fwd)
  );

  assign data1_o    = rs_fwd;
  assign data2_o    = ctrl_q.alu_src ? imm_q : rt_fwd;
  assign MemWdata_o = rt_fwd;
  assign WBaddr_o   = ctrl_q.reg_dst ? rd_addr_q : rt_addr_q;
  assign ALUCtrl_o  = ctrl_q.alu_ctrl;
  assign RegWrite_o = ctrl_q.reg_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal cases plus randomized traffic checked every
// negative clock edge against a behavioural model of the latched instruction.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic [5:0]  funct_i;
  logic [1:0]  ALUOp_i;
  logic        ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [31:0] EXMEM_data_i, MEMWB_data_i;
  logic [31:0] data1_o, data2_o, MemWdata_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  WBaddr_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, hazard_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .RSdata_i         (RSdata_i),
    .RTdata_i         (RTdata_i),
    .imm_i            (imm_i),
    .RSaddr_i         (RSaddr_i),
    .RTaddr_i         (RTaddr_i),
    .RDaddr_i         (RDaddr_i),
    .funct_i          (funct_i),
    .ALUOp_i          (ALUOp_i),
    .ALUSrc_i         (ALUSrc_i),
    .RegDst_i         (RegDst_i),
    .RegWrite_i       (RegWrite_i),
    .MemtoReg_i       (MemtoReg_i),
    .MemRead_i        (MemRead_i),
    .MemWrite_i       (MemWrite_i),
    .EXMEM_RegWrite_i (EXMEM_RegWrite_i),
    .EXMEM_RDaddr_i   (EXMEM_RDaddr_i),
    .EXMEM_data_i     (EXMEM_data_i),
    .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
    .MEMWB_RDaddr_i   (MEMWB_RDaddr_i),
    .MEMWB_data_i     (MEMWB_data_i),
    .data1_o          (data1_o),
    .data2_o          (data2_o),
    .ALUCtrl_o        (ALUCtrl_o),
    .MemWdata_o       (MemWdata_o),
    .WBaddr_o         (WBaddr_o),
    .RegWrite_o       (RegWrite_o),
    .MemtoReg_o       (MemtoReg_o),
    .MemRead_o        (MemRead_o),
    .MemWrite_o       (MemWrite_o),
    .hazard_o         (hazard_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: the instruction currently held in EX ----------------
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rsa, m_rta, m_rda;
  logic [2:0]  m_alu;
  logic        m_src, m_dst, m_rw, m_m2r, m_mr, m_mw;

  function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 3'b110;
    if (op != 2'b10) return 3'b010;
    if (f == 6'b100010) return 3'b110;
    if (f == 6'b100100) return 3'b000;
    if (f == 6'b100101) return 3'b001;
    if (f == 6'b011000) return 3'b100;
    return 3'b010;
  endfunction

  function automatic logic ref_hz();
    return m_mr && (m_rta != 0) && (m_rta == RSaddr_i || m_rta == RTaddr_i);
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && EXMEM_RegWrite_i && EXMEM_RDaddr_i == a) return EXMEM_data_i;
    if (a != 0 && MEMWB_RegWrite_i && MEMWB_RDaddr_i == a) return MEMWB_data_i;
    return d;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || (!stall_i && (flush_i || ref_hz()))) begin
      m_rsd <= 0; m_rtd <= 0; m_imm <= 0; m_rsa <= 0; m_rta <= 0; m_rda <= 0;
      m_alu <= 0; m_src <= 0; m_dst <= 0; m_rw <= 0; m_m2r <= 0; m_mr <= 0; m_mw <= 0;
    end else if (!stall_i) begin
      m_rsd <= RSdata_i; m_rtd <= RTdata_i; m_imm <= imm_i;
      m_rsa <= RSaddr_i; m_rta <= RTaddr_i; m_rda <= RDaddr_i;
      m_alu <= ref_alu(ALUOp_i, funct_i);
      m_src <= ALUSrc_i; m_dst <= RegDst_i; m_rw <= RegWrite_i;
      m_m2r <= MemtoReg_i; m_mr <= MemRead_i; m_mw <= MemWrite_i;
    end
  end

  always @(negedge clk_i) begin
    chk("data1", data1_o, ref_fwd(m_rsa, m_rsd));
    chk("data2", data2_o, m_src ? m_imm : ref_fwd(m_rta, m_rtd));
    chk("memwdata", MemWdata_o, ref_fwd(m_rta, m_rtd));
    chk("aluctrl", {29'd0, ALUCtrl_o}, {29'd0, m_alu});
    chk("wbaddr", {27'd0, WBaddr_o}, {27'd0, (m_dst ? m_rda : m_rta)});
    chk("ctrl", {28'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o},
        {28'd0, m_rw, m_m2r, m_mr, m_mw});
    chk("hazard", {31'd0, hazard_o}, {31'd0, ref_hz()});
  end

  // ---------------- stimulus ----------------
  task automatic clr_in();
    stall_i = 0; flush_i = 0;
    RSdata_i = 0; RTdata_i = 0; imm_i = 0;
    RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0; funct_i = 0; ALUOp_i = 0;
    ALUSrc_i = 0; RegDst_i = 0; RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    EXMEM_RegWrite_i = 0; EXMEM_RDaddr_i = 0; EXMEM_data_i = 0;
    MEMWB_RegWrite_i = 0; MEMWB_RDaddr_i = 0; MEMWB_data_i = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_data1"}, data1_o, 0);
    chk({nm, "_data2"}, data2_o, 0);
    chk({nm, "_memwdata"}, MemWdata_o, 0);
    chk({nm, "_aluctrl"}, {29'd0, ALUCtrl_o}, 0);
    chk({nm, "_wbaddr"}, {27'd0, WBaddr_o}, 0);
    chk({nm, "_ctrl"}, {27'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, hazard_o}, 0);
  endtask

  task automatic rand_in();
    logic [5:0] fl [5];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000};
    RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom;
    RSaddr_i = 5'($urandom_range(0, 7)); RTaddr_i = 5'($urandom_range(0, 7));
    RDaddr_i = 5'($urandom_range(0, 7));
    funct_i = ($urandom_range(0, 1) == 1) ? fl[$urandom_range(0, 4)] : 6'($urandom);
    ALUOp_i = 2'($urandom_range(0, 3));
    {ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemWrite_i} = 5'($urandom);
    MemRead_i = ($urandom_range(0, 2) == 0);
    EXMEM_RegWrite_i = 1'($urandom); EXMEM_RDaddr_i = 5'($urandom_range(0, 7));
    EXMEM_data_i = $urandom;
    MEMWB_RegWrite_i = 1'($urandom); MEMWB_RDaddr_i = 5'($urandom_range(0, 7));
    MEMWB_data_i = $urandom;
    stall_i = ($urandom_range(0, 7) == 0);
    flush_i = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    logic [5:0] sweep_f [5];
    logic [2:0] sweep_c [5];
    sweep_f = '{6'b100010, 6'b100100, 6'b100101, 6'b011000, 6'b111111};
    sweep_c = '{3'b110, 3'b000, 3'b001, 3'b100, 3'b010};

    clr_in();
    rst_i = 1;
    step();
    chk_all_zero("reset");
    rst_i = 0;

    // add $3,$1,$2
    RSaddr_i = 1; RTaddr_i = 2; RDaddr_i = 3; RSdata_i = 5; RTdata_i = 7;
    ALUOp_i = 2'b10; funct_i = 6'b100000; RegDst_i = 1; RegWrite_i = 1;
    step();
    chk("add_data1", data1_o, 5);
    chk("add_data2", data2_o, 7);
    chk("add_aluctrl", {29'd0, ALUCtrl_o}, 3'b010);
    chk("add_wbaddr", {27'd0, WBaddr_o}, 3);
    chk("add_regwrite", {31'd0, RegWrite_o}, 1);

    for (int i = 0; i < 5; i++) begin
      funct_i = sweep_f[i];
      step();
      chk("sweep_aluctrl", {29'd0, ALUCtrl_o}, {29'd0, sweep_c[i]});
    end
    ALUOp_i = 2'b01;
    step();
    chk("beq_aluctrl", {29'd0, ALUCtrl_o}, 3'b110);

    // forwarding priority
    clr_in();
    RSaddr_i = 4; RSdata_i = 5;
    step();
    EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 4; EXMEM_data_i = 32'hAA;
    MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 4; MEMWB_data_i = 32'hBB;
    #1 chk("fwd_exmem", data1_o, 32'hAA);
    EXMEM_RegWrite_i = 0;
    #1 chk("fwd_memwb", data1_o, 32'hBB);
    RSaddr_i = 0; RSdata_i = 32'h55;
    EXMEM_RegWrite_i = 1; EXMEM_RDaddr_i = 0; MEMWB_RDaddr_i = 0;
    step();
    chk("fwd_r0", data1_o, 32'h55);

    // load-use: lw $2 then add $5,$2,$3
    clr_in();
    RSaddr_i = 1; RTaddr_i = 2; imm_i = 4; ALUSrc_i = 1;
    MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1;
    step();
    RSaddr_i = 2; RTaddr_i = 3; RDaddr_i = 5; RegDst_i = 1; ALUSrc_i = 0;
    MemRead_i = 0; MemtoReg_i = 0; ALUOp_i = 2'b10; funct_i = 6'b100000;
    #1 chk("lu_hazard", {31'd0, hazard_o}, 1);
    step();
    chk("lu_bubble_rw", {31'd0, RegWrite_o}, 0);
    chk("lu_bubble_mw", {31'd0, MemWrite_o}, 0);
    chk("lu_hazard_drop", {31'd0, hazard_o}, 0);
    step();
    chk("lu_enter_rw", {31'd0, RegWrite_o}, 1);
    chk("lu_enter_wb", {27'd0, WBaddr_o}, 5);

    // sw with RT forwarded from MEM/WB
    clr_in();
    RSaddr_i = 1; RTaddr_i = 6; RTdata_i = 32'h99; imm_i = 8; ALUSrc_i = 1; MemWrite_i = 1;
    MEMWB_RegWrite_i = 1; MEMWB_RDaddr_i = 6; MEMWB_data_i = 32'h1234;
    step();
    chk("sw_data2", data2_o, 8);
    chk("sw_memwdata", MemWdata_o, 32'h1234);

    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom;
      RSaddr_i = 5'($urandom_range(8, 15)); RTaddr_i = 5'($urandom_range(8, 15));
      MemWrite_i = 0; ALUOp_i = 2'b01;
      step();
      chk("stall_data2", data2_o, 8);
      chk("stall_memwdata", MemWdata_o, 32'h1234);
      chk("stall_mw", {31'd0, MemWrite_o}, 1);
    end
    flush_i = 1;
    step();
    chk("stallflush_mw", {31'd0, MemWrite_o}, 1);
    chk("stallflush_data2", data2_o, 8);
    stall_i = 0;
    step();
    chk("flush_mw", {31'd0, MemWrite_o}, 0);
    chk("flush_data2", data2_o, 0);
    chk("flush_aluctrl", {29'd0, ALUCtrl_o}, 0);
    flush_i = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i);
      #2;
      rand_in();
      if ($urandom_range(0, 299) == 0) begin
        rst_i = 1;
        #2 rst_i = 0;
      end
    end

    // mid-cycle asynchronous reset
    @(posedge clk_i);
    #3 rst_i = 1;
    #1 chk_all_zero("midrst");
    #2 rst_i = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_i);
      #2 rand_in();
    end
    @(posedge clk_i);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that directly feeds the ALU: latches decoded operands and control from ID, generates the 3-bit ALU control code, and forwards EX/MEM and MEM/WB results onto the ALU operands. It also detects load-use hazards and inserts bubbles. Its outputs drive the ALU data/control inputs and the EX/MEM register.

## Interface
- none (fixed 32-bit datapath, 5-bit register addresses)

Ports (clock and reset first):
- clk_i  in  1  pipeline clock, rising edge
- rst_i  in  1  **asynchronous, active-high reset**
- stall_i  in  1  hold stage contents (global stall)
- flush_i  in  1  load a bubble (e.g. taken branch)
- RSdata_i, RTdata_i  in  32  register-file read data
- imm_i  in  32  sign-extended immediate
- RSaddr_i, RTaddr_i, RDaddr_i  in  5  register addresses of the instruction in ID
- funct_i  in  6  R-type funct field
- ALUOp_i  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 add (addi)
- ALUSrc_i, RegDst_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1  control bits from decode
- EXMEM_RegWrite_i  in  1, EXMEM_RDaddr_i  in  5, EXMEM_data_i  in  32  EX/MEM forward source
- MEMWB_RegWrite_i  in  1, MEMWB_RDaddr_i  in  5, MEMWB_data_i  in  32  MEM/WB forward source
- data1_o, data2_o  out  32  ALU operands
- ALUCtrl_o  out  3  ALU control code
- MemWdata_o  out  32  forwarded RT value for stores
- WBaddr_o  out  5  destination register (RD if RegDst, else RT)
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1  to EX/MEM
- hazard_o  out  1  load-use hazard; upstream must hold PC and IF/ID

## Operation
- ALU control decode (before the register, stored as 3 bits):
  - ALUOp 00/11 → 010; ALUOp 01 → 110.
  - ALUOp 10 with funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 011000 → 100. Any other funct → 010.
- Register update priority at each rising edge:
  - stall_i: hold all fields.
  - else flush_i or hazard_o: load a bubble. All control bits are 0, ALUCtrl is 000, and data and address fields are 0.
  - else: load the ID inputs.
- hazard_o is combinational: MemRead_q & (RTaddr_q != 0) & (RTaddr_q == RSaddr_i | RTaddr_q == RTaddr_i).
- Forwarding is combinational and applied per operand (RS, RT):
  - EX/MEM source has priority when EXMEM_RegWrite_i, EXMEM_RDaddr_i != 0, and it equals the operand address.
  - Else the MEM/WB source, under the same conditions.
  - Else the latched register data.
  - Register 0 is never forwarded.
- data1_o is the forwarded RS value.
- data2_o is imm_q when ALUSrc_q is set, else the forwarded RT value.
- MemWdata_o is always the forwarded RT value.
- WBaddr_o is RDaddr_q when RegDst_q is set, else RTaddr_q.
- Same-cycle write-back bypass into ID is the register file's job, not this block's.

## Timing
- Reset (asynchronous, immediate): all registered fields are 0. As a result all outputs read 0: data1_o, data2_o, MemWdata_o, ALUCtrl_o=000, WBaddr_o, control outputs, hazard_o.
- Latency is one cycle from ID inputs to the registered outputs.
- Forwarding and hazard_o follow their inputs in the same cycle, with no added latency.
- A load-use hazard produces exactly one bubble. On the next cycle MemRead_q is 0, so hazard_o drops and the held instruction enters.
- stall_i and hazard in the same cycle: stall wins and contents hold. hazard_o stays asserted while the condition persists.
- stall_i and flush_i together: stall wins.
- rst_i asserted mid-stream clears the stage at once. The first edge after release loads the ID inputs normally.

## Structure
- Shared package holds:
  - ALUOp encodings and R-type funct constants.
  - ALU control codes (ADD=010, SUB=110, AND=000, OR=001, MUL=100), shared with the ALU.
  - A bubble constant for the control bundle.
- One sub-module, `fwd_sel`, is instantiated twice (RS and RT). Inputs: operand address, register data, and both forward sources. Output: the selected 32-bit value.

## Test plan
- Reset: assert rst_i mid-cycle → all outputs 0 immediately. Release, then load add $3,$1,$2 (RS=5, RT=7) → data1_o=5, data2_o=7, ALUCtrl_o=010, WBaddr_o=3.
- Decode sweep with ALUOp=10 and funct 100010/100100/100101/011000/111111 → ALUCtrl_o 110/000/001/100/010. ALUOp 01 → 110.
- Forward priority: RSaddr=4, EXMEM writes $4=0xAA, MEMWB writes $4=0xBB → data1_o=0xAA. Drop EXMEM_RegWrite_i → 0xBB. Use $0 as destination → register data is used.
- Load-use: lw $2 latched, ID has RS=$2 → hazard_o=1. Next edge loads a bubble (RegWrite_o=0, MemWrite_o=0). hazard_o then 0 and the dependent instruction latches.
- Store forwarding: sw with ALUSrc=1, imm=8, RT forwarded from MEMWB 0x1234 → data2_o=8, MemWdata_o=0x1234.
- stall_i for 3 cycles with changing inputs → outputs constant. flush_i and stall_i together → hold. flush_i alone → bubble.
